am_codec_core: RTL



---
 rtl/am_codec_core.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/am_codec_core.sv
// am_codec_core: AM modulator (message x carrier with programmable depth) and
// full-wave-rectifier + boxcar-average envelope demodulator in one clock domain.
// The demodulator takes either an external sample stream or, in LOOP mode,
// the modulator's own output.
module am_codec_core #(
  parameter int MSG_W    = 12,
  parameter int CAR_W    = 8,
  parameter int K_W      = 8,
  parameter int OUT_W    = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       mode,
  input  logic             msg_fmt,
  input  logic             car_fmt,
  input  logic [K_W-1:0]   mod_depth,
  input  logic             in_valid,
  input  logic [MSG_W-1:0] msg_data,
  input  logic [CAR_W-1:0] car_data,
  input  logic [OUT_W-1:0] demod_in,
  output logic [OUT_W-1:0] am_out,
  output logic             am_valid,
  output logic [OUT_W-1:0] demod_out,
  output logic             demod_valid,
  output logic             sat_flag
);

  typedef enum logic [1:0] {
    MODE_MOD   = 2'b00,
    MODE_DEMOD = 2'b01,
    MODE_LOOP  = 2'b10,
    MODE_MOD2  = 2'b11
  } mode_e;

  localparam int MP_W  = MSG_W + K_W + 1;         // message x depth product
  localparam int PP_W  = CAR_W + MSG_W + 2;       // carrier x envelope product
  localparam int SH    = CAR_W + MSG_W + 1 - OUT_W;
  localparam int SUM_W = OUT_W + AVG_LOG2;
  localparam int N     = 1 << AVG_LOG2;

  localparam logic signed [MP_W-1:0] ENV_BIAS  = {{(K_W+1){1'b0}}, 1'b1, {(MSG_W-1){1'b0}}};
  localparam logic [AVG_LOG2:0]      FILL_FULL = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [AVG_LOG2:0]      FILL_ONE  = {{AVG_LOG2{1'b0}}, 1'b1};
  localparam logic [AVG_LOG2-1:0]    WP_ONE    = FILL_ONE[AVG_LOG2-1:0];
  localparam logic [OUT_W-1:0]       X_MIN     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]       X_MAX     = {1'b0, {(OUT_W-1){1'b1}}};

  // ---------------------------------------------------------------- modulator
  logic                    r_s0_valid;
  logic signed [MSG_W-1:0] r_s0_msg;
  logic signed [CAR_W-1:0] r_s0_car;
  logic [K_W-1:0]          r_s0_depth;
  logic                    r_s1_valid;
  logic [MSG_W:0]          r_s1_env;
  logic signed [CAR_W-1:0] r_s1_car;
  logic                    r_s2_valid;
  logic [OUT_W-1:0]        r_s2_am;
  logic                    r_am_valid;
  logic [OUT_W-1:0]        r_am_out;

  logic signed [MSG_W-1:0] w_msg_s;
  logic signed [CAR_W-1:0] w_car_s;
  logic signed [MP_W-1:0]  w_mprod;
  logic signed [MP_W-1:0]  w_mshift;
  logic signed [MP_W-1:0]  w_env_full;
  logic [MSG_W:0]          w_env;
  logic signed [PP_W-1:0]  w_prod;
  logic                    w_unused;

  // Offset-binary to two's complement is just an MSB flip.
  assign w_msg_s    = msg_data ^ {msg_fmt, {(MSG_W-1){1'b0}}};
  assign w_car_s    = car_data ^ {car_fmt, {(CAR_W-1){1'b0}}};

  // Envelope = half scale + message scaled by depth/2^K_W (floor via arithmetic shift).
  assign w_mprod    = MP_W'(r_s0_msg) * MP_W'($signed({1'b0, r_s0_depth}));
  assign w_mshift   = w_mprod >>> K_W;
  assign w_env_full = w_mshift + ENV_BIAS;
  assign w_env      = w_env_full[MSG_W:0];

  // Envelope is always positive, so it enters the product as a zero-extended value.
  assign w_prod     = PP_W'(r_s1_car) * PP_W'($signed({1'b0, r_s1_env}));

  // Upper product bits and the dropped fraction are intentionally discarded.
  assign w_unused   = ^{w_env_full, w_prod};

  logic w_flush;
  mode_e r_mode;
  assign w_flush = (mode != r_mode);

  // Modulator pipeline: capture/convert, envelope, product, output register.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s0_valid <= 1'b0;
      r_s0_msg   <= '0;
      r_s0_car   <= '0;
      r_s0_depth <= '0;
      r_s1_valid <= 1'b0;
      r_s1_env   <= '0;
      r_s1_car   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_am    <= '0;
      r_am_valid <= 1'b0;
      r_am_out   <= '0;
    end else if (w_flush) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_am_valid <= 1'b0;
    end else begin
      r_s0_valid <= in_valid;
      if (in_valid) begin
        r_s0_msg   <= w_msg_s;
        r_s0_car   <= w_car_s;
        r_s0_depth <= mod_depth;
      end
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_env <= w_env;
        r_s1_car <= r_s0_car;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_am <= w_prod[CAR_W+MSG_W:SH];
      r_am_valid <= r_s2_valid;
      if (r_s2_valid) r_am_out <= r_s2_am;
    end
  end

  assign am_out   = r_am_out;
  assign am_valid = r_am_valid;

  // -------------------------------------------------------------- demodulator
  logic                r_d0_valid;
  logic [OUT_W-1:0]    r_d0_x;
  logic                r_d1_valid;
  logic [OUT_W-1:0]    r_d1_rect;
  logic                r_d2_valid;
  logic                r_d2_full;
  logic [SUM_W-1:0]    r_sum;
  logic [AVG_LOG2:0]   r_fill;
  logic [AVG_LOG2-1:0] r_wp;
  logic [OUT_W-1:0]    r_buf [N];
  logic                r_demod_valid;
  logic [OUT_W-1:0]    r_demod_out;
  logic                r_sat;

  logic                w_src_valid;
  logic [OUT_W-1:0]    w_src_data;
  logic                w_is_min;
  logic [OUT_W-1:0]    w_rect;
  logic [OUT_W-1:0]    w_old;
  logic [SUM_W-1:0]    w_sum_next;
  logic [AVG_LOG2:0]   w_fill_next;

  // Select the demodulator source for the active mode.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_src_valid = 1'b0;
    w_src_data  = demod_in;
    case (r_mode)
      MODE_DEMOD: w_src_valid = in_valid;
      MODE_LOOP: begin
        w_src_valid = r_am_valid;
        w_src_data  = r_am_out;
      end
      default: w_src_valid = 1'b0;
    endcase
  end

  // Full-wave rectifier; the most negative code has no positive twin, so clamp it.
  assign w_is_min    = (r_d0_x == X_MIN);
  assign w_rect      = w_is_min ? X_MAX : (r_d0_x[OUT_W-1] ? -r_d0_x : r_d0_x);

  // Running sum drops the oldest sample only once the window is full.
  assign w_old       = (r_fill == FILL_FULL) ? r_buf[r_wp] : '0;
  assign w_sum_next  = r_sum + {{AVG_LOG2{1'b0}}, r_d1_rect} - {{AVG_LOG2{1'b0}}, w_old};
  assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_ONE;

  // Mode register, demod pipeline (capture, rectify, accumulate, output) and sticky saturation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode        <= MODE_MOD;
      r_d0_valid    <= 1'b0;
      r_d0_x        <= '0;
      r_d1_valid    <= 1'b0;
      r_d1_rect     <= '0;
      r_d2_valid    <= 1'b0;
      r_d2_full     <= 1'b0;
      r_sum         <= '0;
      r_fill        <= '0;
      r_wp          <= '0;
      r_demod_valid <= 1'b0;
      r_demod_out   <= '0;
      r_sat         <= 1'b0;
    end else if (w_flush) begin
      r_mode        <= mode_e'(mode);
      r_d0_valid    <= 1'b0;
      r_d1_valid    <= 1'b0;
      r_d2_valid    <= 1'b0;
      r_d2_full     <= 1'b0;
      r_sum         <= '0;
      r_fill        <= '0;
      r_wp          <= '0;
      r_demod_valid <= 1'b0;
    end else begin
      r_d0_valid <= w_src_valid;
      if (w_src_valid) r_d0_x <= w_src_data;
      r_d1_valid <= r_d0_valid;
      if (r_d0_valid) begin
        r_d1_rect <= w_rect;
        if (w_is_min) r_sat <= 1'b1;
      end
      r_d2_valid <= r_d1_valid;
      if (r_d1_valid) begin
        r_sum     <= w_sum_next;
        r_fill    <= w_fill_next;
        r_wp      <= r_wp + WP_ONE;
        r_d2_full <= (w_fill_next == FILL_FULL);
      end
      r_demod_valid <= r_d2_valid && r_d2_full;
      if (r_d2_valid) r_demod_out <= r_sum[SUM_W-1:AVG_LOG2];
    end
  end

  // Boxcar window storage, written at the accumulate stage.
  // NOTE: the window RAM is not reset; the fill count masks stale entries.
  always_ff @(posedge CLK) begin
    if (!RST && !w_flush && r_d1_valid) r_buf[r_wp] <= r_d1_rect;
  end

  assign demod_out   = r_demod_out;
  assign demod_valid = r_demod_valid;
  assign sat_flag    = r_sat;

endmodule
